// File: rtl/pipelined_shift_unit_pkg.sv
// Shared definitions for the pipelined shift unit: operation encodings and
// the per-stage control payload that travels alongside data, shamt and tag.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRA = 2'b11
    } shift_op_e;

    // Width-independent part of a stage payload; data/shamt/tag widths follow
    // the unit's parameters and are carried as separate stage ports.
    typedef struct packed {
        logic      valid;
        shift_op_e op;
        logic      word;
    } stage_ctrl_t;

endpackage

// File: rtl/pipelined_shift_unit_if.sv
// Issue-side and writeback-side handshake bundle of the pipelined shift unit.
interface pipelined_shift_unit_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    parameter int SHW   = $clog2(XLEN)
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_word;
    logic [XLEN-1:0]  in_data;
    logic [SHW-1:0]   in_shamt;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;

    // Both sides: a transfer happens on a rising edge where valid && ready;
    // the unit's in_ready equals !out_valid || out_ready, and out_* stay
    // stable while out_valid is high and out_ready is low.
    modport master (
        output in_valid, in_op, in_word, in_data, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_word, in_data, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/pipelined_shift_unit_stage.sv
// One level of the shift network: conditional shift/rotate by 2**LVL,
// followed by the stage's pipeline register with hold enable and flush.
module shift_stage
    import shift_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    parameter int SHW   = $clog2(XLEN),
    parameter int LVL   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             en_i,
    input  logic [XLEN-1:0]  data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [TAG_W-1:0] tag_i,
    input  stage_ctrl_t      ctrl_i,
    output logic [XLEN-1:0]  data_o,
    output logic [SHW-1:0]   shamt_o,
    output logic [TAG_W-1:0] tag_o,
    output stage_ctrl_t      ctrl_o
);
    localparam int SH = 1 << LVL;

    logic [XLEN-1:0]  data_d;
    logic [XLEN-1:0]  data_q;
    logic [SHW-1:0]   shamt_q;
    logic [TAG_W-1:0] tag_q;
    stage_ctrl_t      ctrl_q;

    always_comb begin
        data_d = data_i;
        if (shamt_i[LVL]) begin
            case (ctrl_i.op)
                OP_SLL:  data_d = data_i << SH;
                OP_SRL:  data_d = data_i >> SH;
                OP_ROR:  data_d = (data_i >> SH) | (data_i << (XLEN - SH));
                OP_SRA:  data_d = $signed(data_i) >>> SH;
                default: data_d = data_i;
            endcase
        end
    end

    // Flush only kills the valid bit; payload registers may keep stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            shamt_q <= '0;
            tag_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            if (en_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                tag_q   <= tag_i;
                ctrl_q  <= ctrl_i;
            end
            if (flush_i) begin
                ctrl_q.valid <= 1'b0;
            end
        end
    end

    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign tag_o   = tag_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined SLL/SRL/ROR/SRA unit with RV64 word variants: one shift level per
// stage (largest first), word pre-processing at entry and sign-extension at exit.
module pipelined_shift_unit
    import shift_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TAG_W   = 5,
    parameter int WORD_EN = 1
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   flush,
    pipelined_shift_unit_if.slave bus
);
    localparam int SHW     = $clog2(XLEN);
    localparam bit WORD_OK = (WORD_EN != 0) && (XLEN == 64);

    logic [XLEN-1:0]  s_data  [SHW+1];
    logic [SHW-1:0]   s_shamt [SHW+1];
    logic [TAG_W-1:0] s_tag   [SHW+1];
    stage_ctrl_t      s_ctrl  [SHW+1];

    logic             advance;
    logic [XLEN-1:0]  pre_data;
    logic [SHW-1:0]   pre_shamt;
    shift_op_e        pre_op;
    logic             pre_word;

    // The whole pipeline moves together; bubbles are not compressed.
    assign advance      = !s_ctrl[SHW].valid || bus.out_ready;
    assign bus.in_ready = advance;

    generate
        if (WORD_OK) begin : g_word
            always_comb begin
                pre_data  = bus.in_data;
                pre_shamt = bus.in_shamt;
                pre_op    = shift_op_e'(bus.in_op);
                pre_word  = bus.in_word;
                if (bus.in_word) begin
                    pre_shamt[SHW-1] = 1'b0;
                    case (shift_op_e'(bus.in_op))
                        OP_SRL: pre_data = {32'b0, bus.in_data[31:0]};
                        OP_SRA: pre_data = {{32{bus.in_data[31]}}, bus.in_data[31:0]};
                        // A doubled word shifted right by < 32 leaves the rotated word in the low half.
                        OP_ROR: begin
                            pre_data = {bus.in_data[31:0], bus.in_data[31:0]};
                            pre_op   = OP_SRL;
                        end
                        default: pre_data = bus.in_data;
                    endcase
                end
            end

            assign bus.out_data = s_ctrl[SHW].word
                                ? {{32{s_data[SHW][31]}}, s_data[SHW][31:0]}
                                : s_data[SHW];
        end else begin : g_noword
            assign pre_data     = bus.in_data;
            assign pre_shamt    = bus.in_shamt;
            assign pre_op       = shift_op_e'(bus.in_op);
            assign pre_word     = 1'b0;
            assign bus.out_data = s_data[SHW];
        end
    endgenerate

    assign s_data[0]  = pre_data;
    assign s_shamt[0] = pre_shamt;
    assign s_tag[0]   = bus.in_tag;
    assign s_ctrl[0]  = '{valid: bus.in_valid, op: pre_op, word: pre_word};

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .XLEN  (XLEN),
            .TAG_W (TAG_W),
            .SHW   (SHW),
            .LVL   (SHW - 1 - k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .en_i    (advance),
            .data_i  (s_data[k]),
            .shamt_i (s_shamt[k]),
            .tag_i   (s_tag[k]),
            .ctrl_i  (s_ctrl[k]),
            .data_o  (s_data[k+1]),
            .shamt_o (s_shamt[k+1]),
            .tag_o   (s_tag[k+1]),
            .ctrl_o  (s_ctrl[k+1])
        );
    end

    assign bus.out_valid = s_ctrl[SHW].valid;
    assign bus.out_tag   = s_tag[SHW];

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Bench for pipelined_shift_unit: directed vectors, stall/flush/reset cases and
// random traffic scored against an arithmetic reference of the shift rules.
module tb_pipelined_shift_unit;
    import shift_pkg::*;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;
    localparam int SHW   = 6;
    localparam int EW    = TAG_W + XLEN;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    pipelined_shift_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    pipelined_shift_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .WORD_EN(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    // ---------------- clock / cycle count / backpressure ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int stall_lo = -1;
    int stall_hi = -2;
    bit rand_bp  = 1'b0;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (cyc >= stall_lo && cyc <= stall_hi) bus.out_ready = 1'b0;
            else if (rand_bp)                       bus.out_ready = ($urandom_range(0, 3) != 0);
            else                                    bus.out_ready = 1'b1;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic word,
                                              input logic [63:0] a, input logic [5:0] sh);
        logic [31:0]        lo;
        logic [31:0]        r32;
        logic signed [31:0] slo;
        logic signed [63:0] sa;
        logic [63:0]        r;
        int                 s;
        if (word) begin
            s   = int'(sh[4:0]);
            lo  = a[31:0];
            slo = a[31:0];
            case (op)
                2'b00:   r32 = lo << s;
                2'b01:   r32 = lo >> s;
                2'b10:   r32 = (s == 0) ? lo : ((lo >> s) | (lo << (32 - s)));
                default: r32 = slo >>> s;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            s  = int'(sh);
            sa = a;
            case (op)
                2'b00:   r = a << s;
                2'b01:   r = a >> s;
                2'b10:   r = (s == 0) ? a : ((a >> s) | (a << (64 - s)));
                default: r = sa >>> s;
            endcase
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            lat_q[$];
    int            pop_count = 0;
    logic          prev_stall = 1'b0;
    logic [63:0]   prev_data;
    logic [4:0]    prev_tag;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            p;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !flush) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_data", bus.out_data, prev_data);
                check("stall_tag", 64'(bus.out_tag), 64'(prev_tag));
            end
            if (bus.out_valid && !bus.out_ready)
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    p = lat_q.pop_front();
                    check("out_data", bus.out_data, e[63:0]);
                    check("out_tag", 64'(bus.out_tag), 64'(e[EW-1:64]));
                    if (p >= 0) check("latency", 64'(cyc - p), 64'(SHW));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready && !flush;
            prev_data  = bus.out_data;
            prev_tag   = bus.out_tag;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic word, input logic [63:0] data,
                        input logic [5:0] sh, input logic [4:0] tag,
                        input logic [63:0] exp, input bit chk_lat);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_word  = word;
        bus.in_data  = data;
        bus.in_shamt = sh;
        bus.in_tag   = tag;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!bus.in_ready) begin
            check("send_in_ready", 64'(bus.in_ready), 64'd1);
        end else begin
            exp_q.push_back({tag, exp});
            lat_q.push_back(chk_lat ? cyc : -1);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [1:0]  op;
        logic        word;
        logic [63:0] data;
        logic [5:0]  sh;
        op   = 2'($urandom_range(0, 3));
        word = 1'($urandom_range(0, 1));
        data = {$urandom, $urandom};
        sh   = 6'($urandom_range(0, 63));
        send(op, word, data, sh, 5'($urandom_range(0, 31)), ref_model(op, word, data, sh), 1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            tick();
            guard++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        lat_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int pops0;
        rst          = 1'b1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_word  = 1'b0;
        bus.in_data  = '0;
        bus.in_shamt = '0;
        bus.in_tag   = '0;
        tick();
        tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed vectors, back to back, with latency checks.
        send(2'b11, 1'b0, 64'h8000000000000000, 6'd4,  5'h03, 64'hF800000000000000, 1'b1);
        send(2'b11, 1'b1, 64'h0000000080000000, 6'd4,  5'h04, 64'hFFFFFFFFF8000000, 1'b1);
        send(2'b00, 1'b1, 64'h0000000000000001, 6'd31, 5'h05, 64'hFFFFFFFF80000000, 1'b1);
        send(2'b10, 1'b0, 64'h0000000000000001, 6'd1,  5'h06, 64'h8000000000000000, 1'b1);
        send(2'b10, 1'b1, 64'h00000000000000F0, 6'd8,  5'h07, 64'hFFFFFFFFF0000000, 1'b1);
        send(2'b11, 1'b0, 64'h8123456789ABCDEF, 6'd0,  5'h08, 64'h8123456789ABCDEF, 1'b1);
        send(2'b01, 1'b1, 64'h1234567880000001, 6'd32, 5'h09, 64'hFFFFFFFF80000001, 1'b1);
        send(2'b10, 1'b0, 64'h0000000000000001, 6'd63, 5'h0A, 64'h0000000000000002, 1'b1);
        send(2'b01, 1'b0, 64'h8000000000000000, 6'd63, 5'h0B, 64'h0000000000000001, 1'b1);
        drain();

        // Eight back-to-back SLLs with a three-cycle output stall.
        pops0    = pop_count;
        base     = cyc;
        stall_lo = base + 7;
        stall_hi = base + 9;
        for (int i = 0; i < 8; i++)
            send(2'b00, 1'b0, 64'h1, 6'(i), 5'(i), 64'h1 << i, 1'b0);
        drain();
        check("stall_pop_count", 64'(pop_count - pops0), 64'd8);
        stall_lo = -1;
        stall_hi = -2;

        // Three ops in flight, flush together with a fourth presented op.
        for (int i = 0; i < 3; i++)
            send(2'b01, 1'b0, 64'hFFFF, 6'(i + 1), 5'(16 + i), 64'hFFFF >> (i + 1), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b00;
        bus.in_word  = 1'b0;
        bus.in_data  = 64'h5;
        bus.in_shamt = 6'd2;
        bus.in_tag   = 5'h13;
        flush        = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        clear_model();
        send(2'b01, 1'b0, 64'h00000000000000F0, 6'd4, 5'h1A, 64'h000000000000000F, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("flush_quiet", 64'(bus.out_valid), 64'd0);
            tick();
        end
        drain();

        // Reset with four ops in flight, the oldest sitting at the output.
        for (int i = 0; i < 4; i++)
            send(2'b00, 1'b0, 64'h3, 6'(i + 1), 5'(20 + i), 64'h3 << (i + 1), 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_out_data", bus.out_data, 64'd0);
        check("mid_rst_out_tag", 64'(bus.out_tag), 64'd0);
        clear_model();
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        send(2'b11, 1'b0, 64'hF000000000000000, 6'd60, 5'h1F, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        drain();

        // Random traffic under random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_rand();
            if ($urandom_range(0, 4) == 0) tick();
        end
        drain();
        rand_bp = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
